inst_fetch_axi: RTL and testbench

- AXI4 read initiator that fetches one 32-bit instruction per PC request from instruction memory for the core pipeline.
- Sits between the core's PC stage and the instruction-memory AXI slave. It drives the slave's read address and read data channels, and returns instructions with a valid/stall handshake.
- Supports flush of in-flight fetches and reports bus/alignment errors.

---
 rtl/inst_fetch_axi.sv | 105 ++++++++++
 tb/tb_inst_fetch_axi.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_axi.sv
// inst_fetch_axi: single-beat AXI4 read initiator fetching one instruction per PC request
module inst_fetch_axi #(
    parameter int          C_AXI_DATA_WIDTH = 32,
    parameter int          C_OFFSET_WIDTH   = 28,
    parameter logic [31:0] C_BASE_ADDR      = 32'h0000_0000
) (
    input  logic                        CCLK,
    input  logic                        CRST_N,
    input  logic                        PC_VALID,
    input  logic [31:0]                 PC,
    input  logic                        FLUSH,
    input  logic                        STALL,
    output logic                        INST_VALID,
    output logic [C_AXI_DATA_WIDTH-1:0] INST,
    output logic                        INST_ERR,
    output logic                        INST_MEM_WAIT,
    output logic [31:0]                 M_AXI_ARADDR,
    output logic [7:0]                  M_AXI_ARLEN,
    output logic [2:0]                  M_AXI_ARSIZE,
    output logic [1:0]                  M_AXI_ARBURST,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RLAST,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);
    typedef enum logic [1:0] {IDLE, AR, R, HOLD} state_t;
    state_t state;
    logic discard;
    logic first;
    logic accept;
    logic kill;
    logic unused;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign accept = PC_VALID && (state == IDLE || (state == HOLD && (!STALL || FLUSH)));
    assign kill   = discard || FLUSH;
    assign unused = ^PC[31:C_OFFSET_WIDTH];
    // fetch sequencer: all outputs registered, a flushed fetch still drains its beats
    always_ff @(posedge CCLK) begin
        if (!CRST_N) begin
            state         <= IDLE;
            discard       <= 1'b0;
            first         <= 1'b0;
            INST_VALID    <= 1'b0;
            INST          <= '0;
            INST_ERR      <= 1'b0;
            INST_MEM_WAIT <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else if (accept) begin
            INST_VALID <= PC[1:0] != 2'b00;
            if (PC[1:0] == 2'b00) begin
                state         <= AR;
                M_AXI_ARADDR  <= {C_BASE_ADDR[31:C_OFFSET_WIDTH], PC[C_OFFSET_WIDTH-1:2], 2'b00};
                M_AXI_ARVALID <= 1'b1;
                INST_MEM_WAIT <= 1'b1;
            end else begin
                state    <= HOLD;
                INST     <= '0;
                INST_ERR <= 1'b1;
            end
        end else begin
            case (state)
                AR: begin
                    if (FLUSH) discard <= 1'b1;
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        first         <= 1'b1;
                        state         <= R;
                    end
                end
                R: begin
                    if (FLUSH) discard <= 1'b1;
                    if (M_AXI_RVALID) begin
                        first <= 1'b0;
                        if (first) begin
                            INST     <= M_AXI_RDATA;
                            INST_ERR <= |M_AXI_RRESP;
                        end
                        if (M_AXI_RLAST) begin
                            M_AXI_RREADY  <= 1'b0;
                            INST_MEM_WAIT <= 1'b0;
                            discard       <= 1'b0;
                            INST_VALID    <= !kill;
                            state         <= kill ? IDLE : HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (FLUSH || !STALL) begin
                        INST_VALID <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_axi.sv
// tb_inst_fetch_axi: directed checks of the instruction fetch AXI initiator
module tb_inst_fetch_axi;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_err;
    logic        mem_wait;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    int          vectors = 0;
    int          miscompares = 0;

    inst_fetch_axi dut (
        .CCLK(clk), .CRST_N(rst_n), .PC_VALID(pc_valid), .PC(pc), .FLUSH(flush), .STALL(stall),
        .INST_VALID(inst_valid), .INST(inst), .INST_ERR(inst_err), .INST_MEM_WAIT(mem_wait),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
        .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".inst_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, ".inst"}, inst, 32'd0);
        chk({tag, ".inst_err"}, {31'd0, inst_err}, 32'd0);
        chk({tag, ".mem_wait"}, {31'd0, mem_wait}, 32'd0);
        chk({tag, ".arvalid"}, {31'd0, arvalid}, 32'd0);
        chk({tag, ".rready"}, {31'd0, rready}, 32'd0);
        chk({tag, ".araddr"}, araddr, 32'd0);
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        rlast  = last;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic issue(input logic [31:0] addr);
        pc_valid = 1'b1;
        pc       = addr;
        tick();
        pc_valid = 1'b0;
    endtask

    initial begin
        // reset state and constant AR fields
        tick();
        tick();
        chk_all_zero("reset");
        chk("arlen", {24'd0, arlen}, 32'd0);
        chk("arsize", {29'd0, arsize}, 32'd2);
        chk("arburst", {30'd0, arburst}, 32'd1);
        rst_n   = 1'b1;
        arready = 1'b1;
        tick();

        // minimum latency fetch of 0x10
        issue(32'h10);
        chk("t1.arvalid", {31'd0, arvalid}, 32'd1);
        chk("t1.araddr", araddr, 32'h10);
        chk("t1.wait_ar", {31'd0, mem_wait}, 32'd1);
        tick();
        chk("t1.rready", {31'd0, rready}, 32'd1);
        chk("t1.arvalid_low", {31'd0, arvalid}, 32'd0);
        beat(32'h00500093, 2'b00, 1'b1);
        chk("t1.inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("t1.inst", inst, 32'h00500093);
        chk("t1.inst_err", {31'd0, inst_err}, 32'd0);
        chk("t1.wait_done", {31'd0, mem_wait}, 32'd0);
        chk("t1.rready_low", {31'd0, rready}, 32'd0);
        tick();
        chk("t1.consumed", {31'd0, inst_valid}, 32'd0);

        // slow slave: ARREADY after 5 cycles, RVALID after 3
        arready = 1'b0;
        issue(32'h40);
        for (int i = 0; i < 5; i++) begin
            chk("t2.arvalid_hold", {31'd0, arvalid}, 32'd1);
            chk("t2.araddr_hold", araddr, 32'h40);
            chk("t2.wait_ar", {31'd0, mem_wait}, 32'd1);
            tick();
        end
        arready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t2.rready_hold", {31'd0, rready}, 32'd1);
            chk("t2.wait_r", {31'd0, mem_wait}, 32'd1);
            chk("t2.no_valid", {31'd0, inst_valid}, 32'd0);
            tick();
        end
        beat(32'hAAAA5555, 2'b00, 1'b1);
        chk("t2.inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("t2.inst", inst, 32'hAAAA5555);
        tick();
        chk("t2.single_pulse", {31'd0, inst_valid}, 32'd0);

        // stall holds the instruction, new request on the consume cycle
        issue(32'h10);
        tick();
        stall = 1'b1;
        beat(32'h00500093, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t3.stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("t3.stall_inst", inst, 32'h00500093);
            tick();
        end
        chk("t3.still_valid", {31'd0, inst_valid}, 32'd1);
        stall = 1'b0;
        issue(32'h20);
        chk("t3.consumed", {31'd0, inst_valid}, 32'd0);
        chk("t3.arvalid_next", {31'd0, arvalid}, 32'd1);
        chk("t3.araddr_next", araddr, 32'h20);
        tick();
        beat(32'h11111111, 2'b00, 1'b1);
        chk("t3.inst2", inst, 32'h11111111);
        tick();

        // flush during R discards the in-flight fetch
        issue(32'h30);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4.wait_after_flush", {31'd0, mem_wait}, 32'd1);
        beat(32'hDEADBEEF, 2'b00, 1'b1);
        chk("t4.discarded", {31'd0, inst_valid}, 32'd0);
        chk("t4.wait_clear", {31'd0, mem_wait}, 32'd0);
        issue(32'h20);
        chk("t4.araddr", araddr, 32'h20);
        tick();
        beat(32'h22222222, 2'b00, 1'b1);
        chk("t4.inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("t4.inst", inst, 32'h22222222);
        tick();

        // error response on a two-beat reply: first beat wins
        issue(32'h50);
        tick();
        beat(32'hBAD0BAD0, 2'b10, 1'b0);
        chk("t5.rready_extra", {31'd0, rready}, 32'd1);
        chk("t5.no_valid_mid", {31'd0, inst_valid}, 32'd0);
        beat(32'h12345678, 2'b00, 1'b1);
        chk("t5.inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("t5.inst_err", {31'd0, inst_err}, 32'd1);
        chk("t5.inst", inst, 32'hBAD0BAD0);
        tick();

        // misaligned PC: immediate error, no bus access
        issue(32'h22);
        chk("t5.mis_arvalid", {31'd0, arvalid}, 32'd0);
        chk("t5.mis_valid", {31'd0, inst_valid}, 32'd1);
        chk("t5.mis_err", {31'd0, inst_err}, 32'd1);
        chk("t5.mis_inst", inst, 32'd0);
        chk("t5.mis_wait", {31'd0, mem_wait}, 32'd0);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        chk("t5.flush_hold", {31'd0, inst_valid}, 32'd0);

        // reset while in R, then a clean fetch
        issue(32'h10);
        tick();
        chk("t6.in_r", {31'd0, rready}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk_all_zero("t6.reset");
        rst_n = 1'b1;
        issue(32'h10);
        chk("t6.araddr", araddr, 32'h10);
        tick();
        beat(32'h00500093, 2'b00, 1'b1);
        chk("t6.inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("t6.inst", inst, 32'h00500093);
        chk("t6.inst_err", {31'd0, inst_err}, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
